pending_encoder: RTL and testbench

//  Sequential 8-to-4 encoder; inverse of the team's 4-to-8 one-hot decoder.

---
 rtl/pending_encoder.sv | 102 ++++++++++
 tb/tb_pending_encoder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pending_encoder.sv
`default_nettype none
// ============================================================================
// Module  : pending_encoder
// Brief   : Sticky-pending 8-to-4 encoder emitting decoder-format codes over valid/ready.
// Revision: 1.0
// ============================================================================
module pending_encoder #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] code,
    output logic [7:0] pending
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] code_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic       acc;
    logic [7:0] smask;
    logic [7:0] cand;
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;

    assign out_valid = (state == SEND);

    // The served bit drops on accept, but a same-cycle request re-arms it.
    always_comb begin
        acc     = out_valid & out_ready;
        smask   = acc ? (8'b0000_0001 << code[2:0]) : 8'h00;
        cand    = (pending & ~smask) | req;
        ptr_nxt = acc ? (code[2:0] + 3'd1) : ptr;
    end

    // Search uses the post-accept pointer so the just-served index ranks last.
    always_comb begin
        sel   = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ROUND_ROBIN ? (ptr_nxt + k[2:0]) : k[2:0];
            if (!found && cand[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        case (state)
            IDLE: begin
                if (cand != 8'h00) begin
                    state_nxt = SEND;
                    code_nxt  = {1'b1, sel};
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (cand != 8'h00) begin
                        code_nxt = {1'b1, sel};
                    end else begin
                        state_nxt = IDLE;
                        code_nxt  = 4'b0000;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                code_nxt  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            code    <= 4'b0000;
            pending <= 8'h00;
            ptr     <= 3'd0;
        end else begin
            state   <= state_nxt;
            code    <= code_nxt;
            pending <= cand;
            ptr     <= ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pending_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_pending_encoder
// Brief   : Directed scoreboard bench for round-robin and fixed-priority encoders.
// Revision: 1.0
// ============================================================================
module tb_pending_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       out_ready;
    logic       rr_valid;
    logic [3:0] rr_code;
    logic [7:0] rr_pending;
    logic       fp_valid;
    logic [3:0] fp_code;
    logic [7:0] fp_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [3:0] code;
        logic [7:0] pend;
        bit         chk_fp;
        logic       fvalid;
        logic [3:0] fcode;
        logic [7:0] fpend;
    } exp_t;

    exp_t sb[$];

    pending_encoder #(.ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .out_valid(rr_valid), .code(rr_code), .pending(rr_pending)
    );

    pending_encoder #(.ROUND_ROBIN(1'b0)) u_fp (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .out_valid(fp_valid), .code(fp_code), .pending(fp_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk4(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the post-edge expectation, then compare.
    task automatic step(input logic r, input logic [7:0] q, input logic rdy,
                        input logic ev, input logic [3:0] ec, input logic [7:0] ep,
                        input bit cf, input logic fv, input logic [3:0] fc, input logic [7:0] fpd);
        exp_t e;
        rst       = r;
        req       = q;
        out_ready = rdy;
        e.valid = ev; e.code = ec; e.pend = ep;
        e.chk_fp = cf; e.fvalid = fv; e.fcode = fc; e.fpend = fpd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk4("rr_valid",   {7'd0, rr_valid}, {7'd0, e.valid});
        chk4("rr_code",    {4'd0, rr_code},  {4'd0, e.code});
        chk4("rr_pending", rr_pending,       e.pend);
        if (e.chk_fp) begin
            chk4("fp_valid",   {7'd0, fp_valid}, {7'd0, e.fvalid});
            chk4("fp_code",    {4'd0, fp_code},  {4'd0, e.fcode});
            chk4("fp_pending", fp_pending,       e.fpend);
        end
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; out_ready = 1'b0;
        #1;
        // reset with requests present, then idle
        step(1, 8'hFF, 0, 0, 4'h0, 8'h00, 1, 0, 4'h0, 8'h00);
        step(1, 8'hFF, 0, 0, 4'h0, 8'h00, 1, 0, 4'h0, 8'h00);
        step(0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 0, 4'h0, 8'h00);
        step(0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        // single request
        step(0, 8'h04, 1, 1, 4'hA, 8'h04, 0, 0, 4'h0, 8'h00);
        step(0, 8'h00, 1, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        // round-robin order from ptr 0, twice to confirm the wrap back to 0
        step(1, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        step(0, 8'h81, 1, 1, 4'h8, 8'h81, 0, 0, 4'h0, 8'h00);
        step(0, 8'h00, 1, 1, 4'hF, 8'h80, 0, 0, 4'h0, 8'h00);
        step(0, 8'h00, 1, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        step(0, 8'h81, 1, 1, 4'h8, 8'h81, 0, 0, 4'h0, 8'h00);
        step(0, 8'h00, 1, 1, 4'hF, 8'h80, 0, 0, 4'h0, 8'h00);
        step(0, 8'h00, 1, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        // backpressure accumulation then back-to-back drain
        step(0, 8'h02, 0, 1, 4'h9, 8'h02, 0, 0, 4'h0, 8'h00);
        step(0, 8'h10, 0, 1, 4'h9, 8'h12, 0, 0, 4'h0, 8'h00);
        step(0, 8'h40, 0, 1, 4'h9, 8'h52, 0, 0, 4'h0, 8'h00);
        step(0, 8'h00, 1, 1, 4'hC, 8'h50, 0, 0, 4'h0, 8'h00);
        step(0, 8'h00, 1, 1, 4'hE, 8'h40, 0, 0, 4'h0, 8'h00);
        step(0, 8'h00, 1, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        // re-arm: index 3 requested again while being accepted (ptr is 7 here)
        step(0, 8'h28, 0, 1, 4'hB, 8'h28, 0, 0, 4'h0, 8'h00);
        step(0, 8'h08, 1, 1, 4'hD, 8'h28, 0, 0, 4'h0, 8'h00);
        step(0, 8'h00, 1, 1, 4'hB, 8'h08, 0, 0, 4'h0, 8'h00);
        step(0, 8'h00, 1, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        // mid-transfer reset
        step(0, 8'hF0, 0, 1, 4'hC, 8'hF0, 0, 0, 4'h0, 8'h00);
        step(1, 8'h00, 0, 0, 4'h0, 8'h00, 1, 0, 4'h0, 8'h00);
        // fixed priority vs round robin
        step(0, 8'h22, 1, 1, 4'h9, 8'h22, 1, 1, 4'h9, 8'h22);
        step(0, 8'h00, 1, 1, 4'hD, 8'h20, 1, 1, 4'hD, 8'h20);
        step(0, 8'h00, 1, 0, 4'h0, 8'h00, 1, 0, 4'h0, 8'h00);
        step(0, 8'h81, 1, 1, 4'hF, 8'h81, 1, 1, 4'h8, 8'h81);
        step(0, 8'h00, 1, 1, 4'h8, 8'h01, 1, 1, 4'hF, 8'h80);
        step(0, 8'h00, 1, 0, 4'h0, 8'h00, 1, 0, 4'h0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
